// File: rtl/lzd_pkg.sv
// Shared types and constants for the iterative leading-zero detector / normalizer.
package lzd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CHUNK_W = 16;

  // The count must be able to represent the full width (all-zero operand).
  function automatic int lz_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/lzd_norm_seq_if.sv
// Operand/result handshake bundle. Both sides use valid/ready: a transfer
// happens on a rising clk edge where valid and ready are both high; the
// sender holds valid and its data stable until that edge.
interface lzd_norm_seq_if #(parameter int WIDTH = 64);
  import lzd_pkg::*;

  localparam int LZ_W = lz_width(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [LZ_W-1:0]  out_lz;
  logic [WIDTH-1:0] out_norm;
  logic             out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_lz, out_norm, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_lz, out_norm, out_zero
  );

endinterface

// File: rtl/lzd_16bits.sv
// Combinational 16-bit leading-zero detector: v flags a nonzero input,
// p is the number of zeros above the highest set bit.
module lzd_16bits (
  input  logic [15:0] src,
  output logic [3:0]  p,
  output logic        v
);

  always_comb begin
    p = 4'd0;
    // Scanning upward lets the highest set bit win.
    for (int i = 0; i < 16; i++) begin
      if (src[i]) p = 4'(15 - i);
    end
  end

  assign v = |src;

endmodule

// File: rtl/lzd_norm_seq.sv
// Iterative leading-zero counter and left-normalizer: one 16-bit chunk per
// cycle from the MSB end, then a single shift cycle. WIDTH: multiple of 16, >= 32.
module lzd_norm_seq
  import lzd_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  lzd_norm_seq_if.slave        bus,
  output state_t               dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int LZ_W   = lz_width(WIDTH);
  localparam int IDX_W  = $clog2(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   data_q;
  logic [LZ_W-1:0]    lz_q;
  logic [WIDTH-1:0]   norm_q;
  logic               zero_q;

  logic [CHUNK_W-1:0] chunks [NCHUNK];
  logic [CHUNK_W-1:0] chunk;
  logic [3:0]         chunk_p;
  logic               chunk_v;

  // Chunk 0 is the most significant 16 bits.
  for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
    assign chunks[g] = data_q[WIDTH-1-CHUNK_W*g -: CHUNK_W];
  end

  assign chunk = chunks[idx];

  lzd_16bits u_lzd (
    .src (chunk),
    .p   (chunk_p),
    .v   (chunk_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      data_q        <= '0;
      lz_q          <= '0;
      norm_q        <= '0;
      zero_q        <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_lz    <= '0;
      bus.out_norm  <= '0;
      bus.out_zero  <= 1'b0;
    end else if (flush) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_q       <= bus.in_data;
            idx          <= '0;
            bus.in_ready <= 1'b0;
            state        <= SCAN;
          end
        end
        SCAN: begin
          if (chunk_v) begin
            lz_q  <= LZ_W'(CHUNK_W * int'(idx)) + LZ_W'(chunk_p);
            state <= SHIFT;
          end else if (idx == LAST_IDX) begin
            // All-zero operand: result is known without a shift.
            lz_q   <= LZ_W'(WIDTH);
            norm_q <= '0;
            zero_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SHIFT: begin
          norm_q <= data_q << lz_q;
          zero_q <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          // First DONE cycle loads the output registers; they then hold
          // until the consumer takes the result.
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
            bus.out_lz    <= lz_q;
            bus.out_norm  <= norm_q;
            bus.out_zero  <= zero_q;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_lzd_norm_seq.sv
// Directed bench for lzd_norm_seq (WIDTH=64): latency, results, backpressure,
// flush and asynchronous reset behaviour against hand-computed values.
module tb_lzd_norm_seq;
  import lzd_pkg::*;

  localparam int WIDTH = 64;
  localparam int LZ_W  = 7;

  logic   clk;
  logic   rst_n;
  logic   flush;
  state_t dbg_state;
  int     checks;
  int     failures;

  lzd_norm_seq_if #(.WIDTH(WIDTH)) bus ();

  lzd_norm_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with in_ready high; returns just after the acceptance edge.
  task automatic send(input logic [WIDTH-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom(), $urandom()};
  endtask

  // Counts edges after acceptance until out_valid is seen; -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) begin
        lat = n;
        return;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [LZ_W+WIDTH+3:0] got;
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    got = {bus.in_ready, bus.out_valid, bus.out_lz, bus.out_norm, bus.out_zero, dbg_state == IDLE};
    checks++;
    if (got !== {1'b1, 1'b0, 7'd0, 64'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_values: got %0h expected %0h", got, {1'b1, 1'b0, 7'd0, 64'd0, 1'b0, 1'b1});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input string name, input logic [WIDTH-1:0] d, input int exp_lat,
                            input logic [LZ_W-1:0] exp_lz, input logic [WIDTH-1:0] exp_norm,
                            input logic exp_zero);
    int lat;
    send(d);
    wait_out(lat);
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if ({bus.out_lz, bus.out_norm, bus.out_zero} !== {exp_lz, exp_norm, exp_zero}) begin
      failures++;
      $display("FAIL %s_result: got lz=%0d norm=%h zero=%b expected lz=%0d norm=%h zero=%b",
               name, bus.out_lz, bus.out_norm, bus.out_zero, exp_lz, exp_norm, exp_zero);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL %s_release: got valid/ready=%b expected 01", name, {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [LZ_W+WIDTH+2:0] got;
    logic [LZ_W+WIDTH+2:0] exp;
    exp = {1'b1, 1'b0, 7'd7, 64'h91A2_B3C4_D5E6_F780, 1'b0};
    bus.out_ready = 1'b0;
    send(64'h0123_4567_89AB_CDEF);
    wait_out(lat);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL bp_latency: got %0d expected 3", lat);
    end
    for (int c = 0; c < 10; c++) begin
      got = {bus.out_valid, bus.in_ready, bus.out_lz, bus.out_norm, bus.out_zero};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL bp_hold_cycle%0d: got %h expected %h", c, got, exp);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_release: got valid/ready=%b expected 01", {bus.out_valid, bus.in_ready});
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_flush();
    int seen;
    send(64'd0);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (dbg_state !== SCAN) begin
      failures++;
      $display("FAIL flush_in_scan: got state %0d expected %0d", dbg_state, SCAN);
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({bus.in_ready, dbg_state == IDLE} !== 2'b11) begin
      failures++;
      $display("FAIL flush_to_idle: got ready/idle=%b expected 11", {bus.in_ready, dbg_state == IDLE});
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL flush_no_output: got %0d valid cycles expected 0", seen);
    end
    // flush with in_valid must not accept the operand.
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 64'h1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, dbg_state == IDLE} !== 2'b11) begin
      failures++;
      $display("FAIL flush_blocks_accept: got ready/idle=%b expected 11", {bus.in_ready, dbg_state == IDLE});
    end
    test_basic("after_flush", 64'h0000_FFFF_0000_0000, 4, 7'd16, 64'hFFFF_0000_0000_0000, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    logic [LZ_W+WIDTH+3:0] got;
    send(64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {bus.in_ready, bus.out_valid, bus.out_lz, bus.out_norm, bus.out_zero, dbg_state == IDLE};
    checks++;
    if (got !== {1'b1, 1'b0, 7'd0, 64'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset_values: got %0h expected %0h", got, {1'b1, 1'b0, 7'd0, 64'd0, 1'b0, 1'b1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release: got ready/valid=%b expected 10", {bus.in_ready, bus.out_valid});
    end
    test_basic("after_reset", 64'h0000_0000_0000_8000, 6, 7'd48, 64'h8000_0000_0000_0000, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic("msb",  64'h8000_0000_0000_0000, 3, 7'd0,  64'h8000_0000_0000_0000, 1'b0);
    test_basic("mid",  64'h0000_0000_8000_0000, 5, 7'd32, 64'h8000_0000_0000_0000, 1'b0);
    test_basic("lsb",  64'h0000_0000_0000_0001, 6, 7'd63, 64'h8000_0000_0000_0000, 1'b0);
    test_basic("zero", 64'h0000_0000_0000_0000, 5, 7'd64, 64'h0000_0000_0000_0000, 1'b1);
    test_basic("odd",  64'h0000_0003_C000_0000, 4, 7'd30, 64'hF000_0000_0000_0000, 1'b0);
    test_backpressure();
    test_flush();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
